// File: rtl/layer_compositor_pipe_pkg.sv
// ----------------------------------------------------------------------------
// layer_compositor_pipe_pkg
// Shared definitions for the layer compositor:
//   COLOR_WIDTH      width of a palette index
//   color_idx_t      palette index type
//   COLOR_*          named palette indices (COLOR_NONE = transparent)
//   rgb24_t          packed {r,g,b} pixel, 8 bits per channel
//   color_index_to_rgb  palette index -> 24-bit RGB mapping
//   rgb_half_blend      per-channel (a+b)>>1, truncating
// ----------------------------------------------------------------------------
package layer_compositor_pipe_pkg;

    localparam int COLOR_WIDTH = 4;

    typedef logic [COLOR_WIDTH-1:0] color_idx_t;

    localparam color_idx_t COLOR_NONE    = 4'd0;
    localparam color_idx_t COLOR_BLACK   = 4'd1;
    localparam color_idx_t COLOR_WHITE   = 4'd2;
    localparam color_idx_t COLOR_RED     = 4'd3;
    localparam color_idx_t COLOR_GREEN   = 4'd4;
    localparam color_idx_t COLOR_BLUE    = 4'd5;
    localparam color_idx_t COLOR_YELLOW  = 4'd6;
    localparam color_idx_t COLOR_CYAN    = 4'd7;
    localparam color_idx_t COLOR_MAGENTA = 4'd8;
    localparam color_idx_t COLOR_ORANGE  = 4'd9;
    localparam color_idx_t COLOR_GRAY    = 4'd10;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

    // Unassigned indices (and COLOR_NONE, which never reaches the palette
    // as a winner) map to black.
    function automatic rgb24_t color_index_to_rgb(input color_idx_t idx);
        rgb24_t rgb;
        case (idx)
            COLOR_BLACK:   rgb = 24'h000000;
            COLOR_WHITE:   rgb = 24'hFFFFFF;
            COLOR_RED:     rgb = 24'hFF0000;
            COLOR_GREEN:   rgb = 24'h00FF00;
            COLOR_BLUE:    rgb = 24'h0000FF;
            COLOR_YELLOW:  rgb = 24'hFFFF00;
            COLOR_CYAN:    rgb = 24'h00FFFF;
            COLOR_MAGENTA: rgb = 24'hFF00FF;
            COLOR_ORANGE:  rgb = 24'hFF8000;
            COLOR_GRAY:    rgb = 24'h808080;
            default:       rgb = 24'h000000;
        endcase
        return rgb;
    endfunction

    // Sum in 9 bits so the carry is kept, then drop the LSB: no rounding.
    function automatic rgb24_t rgb_half_blend(input rgb24_t a, input rgb24_t b);
        rgb24_t     res;
        logic [8:0] sum_r;
        logic [8:0] sum_g;
        logic [8:0] sum_b;
        sum_r = {1'b0, a.r} + {1'b0, b.r};
        sum_g = {1'b0, a.g} + {1'b0, b.g};
        sum_b = {1'b0, a.b} + {1'b0, b.b};
        res.r = sum_r[8:1];
        res.g = sum_g[8:1];
        res.b = sum_b[8:1];
        return res;
    endfunction

endpackage

// File: rtl/layer_compositor_pipe_layer_select.sv
// ----------------------------------------------------------------------------
// compositor_layer_select
// Combinational priority select across NUM_LAYERS palette layers. The
// highest-index layer that is visible and not COLOR_NONE wins.
// Ports:
//   layer_color  in   NUM_LAYERS*COLOR_WIDTH  palette index per layer
//   visible      in   NUM_LAYERS              per-layer visibility
//   blend        in   NUM_LAYERS              per-layer blend enable
//   tag          out  SEL_W                   0 = none, i+1 = layer i won
//   index        out  COLOR_WIDTH             winning palette index
//   blend_sel    out  1                       blend bit of the winner
// ----------------------------------------------------------------------------
module compositor_layer_select
    import layer_compositor_pipe_pkg::*;
#(
    parameter int NUM_LAYERS = 5,
    parameter int SEL_W      = $clog2(NUM_LAYERS + 1)
) (
    input  logic [NUM_LAYERS*COLOR_WIDTH-1:0] layer_color,
    input  logic [NUM_LAYERS-1:0]             visible,
    input  logic [NUM_LAYERS-1:0]             blend,
    output logic [SEL_W-1:0]                  tag,
    output color_idx_t                        index,
    output logic                              blend_sel
);

    // Ascending scan: a later (higher) hit overwrites a lower one.
    always_comb begin
        tag       = '0;
        index     = COLOR_NONE;
        blend_sel = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (visible[i] &&
                (layer_color[i*COLOR_WIDTH +: COLOR_WIDTH] != COLOR_NONE)) begin
                tag       = SEL_W'(i + 1);
                index     = layer_color[i*COLOR_WIDTH +: COLOR_WIDTH];
                blend_sel = blend[i];
            end
        end
    end

endmodule

// File: rtl/layer_compositor_pipe.sv
// ----------------------------------------------------------------------------
// layer_compositor_pipe
// Three-stage N-layer compositor between the camera stream and VGA driver.
//   stage 1: priority select of the winning layer (registered)
//   stage 2: palette lookup of the winning index
//   stage 3: mix (camera / palette / 50% blend)
// Visibility and blend config are shadowed and only reloaded on an accepted
// start-of-frame beat, so a frame is always composed with one config.
// Ports:
//   clk          in   1                       system clock
//   reset        in   1                       async reset, active low
//   in_valid     in   1                       input beat valid
//   in_ready     out  1                       input accepted when valid&&ready
//   in_sof       in   1                       first pixel of a frame
//   camera_rgb   in   24                      camera pixel {r,g,b}
//   layer_color  in   NUM_LAYERS*COLOR_WIDTH  palette index per layer
//   cfg_visible  in   NUM_LAYERS              requested visibility
//   cfg_blend    in   NUM_LAYERS              requested blend enable
//   out_valid    out  1                       output beat valid
//   out_ready    in   1                       downstream accepts
//   out_sof      out  1                       sof travelling with its pixel
//   out_rgb      out  24                      composed pixel
//   out_layer    out  SEL_W                   0 = camera, i+1 = layer i
// ----------------------------------------------------------------------------
module layer_compositor_pipe
    import layer_compositor_pipe_pkg::*;
#(
    parameter int NUM_LAYERS = 5,
    parameter int SEL_W      = $clog2(NUM_LAYERS + 1)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_sof,
    input  logic [23:0]                       camera_rgb,
    input  logic [NUM_LAYERS*COLOR_WIDTH-1:0] layer_color,
    input  logic [NUM_LAYERS-1:0]             cfg_visible,
    input  logic [NUM_LAYERS-1:0]             cfg_blend,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_sof,
    output logic [23:0]                       out_rgb,
    output logic [SEL_W-1:0]                  out_layer
);

    logic                  adv;
    logic                  accept;
    logic                  load_cfg;

    logic [NUM_LAYERS-1:0] active_visible;
    logic [NUM_LAYERS-1:0] active_blend;
    logic [NUM_LAYERS-1:0] eff_visible;
    logic [NUM_LAYERS-1:0] eff_blend;

    logic [SEL_W-1:0]      sel_tag;
    color_idx_t            sel_index;
    logic                  sel_blend;

    // stage 1
    logic                  s1_valid;
    logic [SEL_W-1:0]      s1_tag;
    color_idx_t            s1_index;
    logic                  s1_blend;
    rgb24_t                s1_cam;
    logic                  s1_sof;

    // stage 2
    logic                  s2_valid;
    logic [SEL_W-1:0]      s2_tag;
    rgb24_t                s2_pal;
    logic                  s2_blend;
    rgb24_t                s2_cam;
    logic                  s2_sof;

    // stage 3 (output registers)
    logic                  s3_valid;
    logic [SEL_W-1:0]      s3_tag;
    rgb24_t                s3_rgb;
    logic                  s3_sof;

    rgb24_t                mix_rgb;

    // The whole pipe moves as one: any empty output slot or a consuming
    // downstream lets every stage shift.
    assign adv      = out_ready || !s3_valid;
    assign in_ready = adv;
    assign accept   = in_valid && adv;
    assign load_cfg = accept && in_sof;

    // The sof beat itself must see the new config, so bypass the shadow
    // registers on the loading cycle.
    assign eff_visible = load_cfg ? cfg_visible : active_visible;
    assign eff_blend   = load_cfg ? cfg_blend   : active_blend;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_visible <= '0;
            active_blend   <= '0;
        end else if (load_cfg) begin
            active_visible <= cfg_visible;
            active_blend   <= cfg_blend;
        end
    end

    compositor_layer_select #(
        .NUM_LAYERS (NUM_LAYERS),
        .SEL_W      (SEL_W)
    ) u_layer_select (
        .layer_color (layer_color),
        .visible     (eff_visible),
        .blend       (eff_blend),
        .tag         (sel_tag),
        .index       (sel_index),
        .blend_sel   (sel_blend)
    );

    // Data registers only load behind a valid beat so bubbles leave the
    // previous contents (and hence the outputs) untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_tag   <= '0;
            s1_index <= COLOR_NONE;
            s1_blend <= 1'b0;
            s1_cam   <= '0;
            s1_sof   <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_tag   <= sel_tag;
                s1_index <= sel_index;
                s1_blend <= sel_blend;
                s1_cam   <= camera_rgb;
                s1_sof   <= in_sof;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid <= 1'b0;
            s2_tag   <= '0;
            s2_pal   <= '0;
            s2_blend <= 1'b0;
            s2_cam   <= '0;
            s2_sof   <= 1'b0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_tag   <= s1_tag;
                s2_pal   <= color_index_to_rgb(s1_index);
                s2_blend <= s1_blend;
                s2_cam   <= s1_cam;
                s2_sof   <= s1_sof;
            end
        end
    end

    always_comb begin
        mix_rgb = s2_cam;
        if (s2_tag != '0) begin
            if (s2_blend) begin
                mix_rgb = rgb_half_blend(s2_pal, s2_cam);
            end else begin
                mix_rgb = s2_pal;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s3_valid <= 1'b0;
            s3_tag   <= '0;
            s3_rgb   <= '0;
            s3_sof   <= 1'b0;
        end else if (adv) begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_tag <= s2_tag;
                s3_rgb <= mix_rgb;
                s3_sof <= s2_sof;
            end
        end
    end

    assign out_valid = s3_valid;
    assign out_sof   = s3_sof;
    assign out_rgb   = s3_rgb;
    assign out_layer = s3_tag;

endmodule

// File: doc/layer_compositor_pipe.md
Name: layer_compositor_pipe

Overview:
- Pipelined, parametrised N-layer compositor between the camera pixel stream and the VGA driver.
- Per pixel, the highest-index visible, non-transparent layer wins; otherwise the camera pixel passes through.
- Adds optional 50% blend of the winning layer with the camera.
- Visibility/blend config is frame-synchronous: it only changes at start-of-frame, so frames never tear.
- Valid/ready stream with full backpressure.

Parameters:
- NUM_LAYERS, 5, number of palette layers; layer NUM_LAYERS-1 has top priority (cursor), layer 0 is lowest.
- SEL_W, $clog2(NUM_LAYERS+1), width of winning-layer tag.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_sof  in  1  beat is first pixel of a frame.
- camera_rgb  in  24  camera pixel {r,g,b}.
- layer_color  in  NUM_LAYERS*COLOR_WIDTH  palette index per layer; layer i at [i*COLOR_WIDTH +: COLOR_WIDTH].
- cfg_visible  in  NUM_LAYERS  requested per-layer visibility.
- cfg_blend  in  NUM_LAYERS  requested per-layer blend enable.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_sof  out  1  in_sof delayed with its pixel.
- out_rgb  out  24  composed pixel.
- out_layer  out  SEL_W  0 = camera, i+1 = layer i won.

Behaviour:
- Reset (reset=0, async): all stage valids 0. out_valid=0, out_sof=0, out_rgb=0, out_layer=0. Active visible/blend registers = 0 (camera passthrough).
- Advance condition: adv = out_ready || !out_valid; in_ready = adv.
  - All three stages shift together when adv=1; all hold otherwise.
  - Input is accepted only when in_valid && adv.
- Latency: exactly 3 cycles from accepted beat to out_valid when out_ready is held 1. Throughput 1 pixel/clk.
- Config shadow: on an accepted beat with in_sof=1, the active registers load cfg_visible/cfg_blend.
  - That sof beat is composed with the new config.
  - Non-sof beats use the held active config; cfg_* changes mid-frame have no effect until the next sof.
- Stage 1 (register + select):
  - Winner = highest i with active_visible[i] && layer_color[i] != COLOR_NONE.
  - Register winner tag (i+1, or 0 if none), winning color index, that layer's active_blend bit, camera_rgb, sof.
- Stage 2 (palette): winning index converted to 24-bit RGB via the common palette mapping; other fields carried.
- Stage 3 (mix):
  - Tag 0: out_rgb = camera.
  - Tag nonzero, blend=0: out_rgb = palette RGB.
  - Tag nonzero, blend=1: each channel = (layer_ch + camera_ch) >> 1, computed in 9 bits, truncated to 8 bits, no rounding.
- Stall: while out_valid && !out_ready, out_rgb/out_sof/out_layer are stable and no input is accepted.
- Bubbles: invalid beats flow through with valid=0; they never update config or data outputs.
- Boundaries:
  - All layers COLOR_NONE or invisible -> camera.
  - sof during stall -> config loads only on the accepting cycle.
  - Reset mid-frame -> pipeline flushed, config back to 0.

Decomposition:
- Shared package (common): COLOR_WIDTH, COLOR_NONE and named color constants, plus the existing palette conversion module (color_index_to_rgb, reused in stage 2).
- Add an RGB24 packed typedef to the package.
- One sub-module: compositor_layer_select (combinational priority select; outputs tag, index and blend bit), parametrised by NUM_LAYERS.

Test Plan:
- Priority: all 5 layers visible, cursor (layer 4) = COLOR_BLACK, layers 3..0 = WHITE/RED/GREEN/BLUE, camera 12_34_56, sof -> 3 cycles later out_rgb=000000, out_layer=5.
  - Clear layers top-down, each change with a new sof -> FFFFFF, FF0000, 00FF00, 0000FF, then 123456 with out_layer=0.
- Blend: layer 2 = RED, blend[2]=1, camera 12_34_56 -> out_rgb=88_1A_2B.
  - Camera FF_FF_FF, WHITE, blend -> FF_FF_FF.
- Frame-sync config: mid-frame change cfg_visible 00001 -> 00000 -> remaining pixels still blue; first pixel after next in_sof = camera.
- Backpressure: stream 8 pixels, hold out_ready=0 for 4 cycles at pixel 3 -> in_ready=0, out_rgb stable, no pixel lost or duplicated, order preserved.
- Transparency: layer visible but color COLOR_NONE -> falls to next layer/camera.
- Reset: assert reset=0 mid-stream with out_valid=1 -> out_valid=0 immediately (async).
  - After release, with no sof yet, stale config cleared -> camera passthrough.
